// File: rtl/al_accel_ibuf_ctrl_pkg.sv
// Shared definitions for the ibuf sequencer: FSM state encoding, scan direction,
// write-strobe codes and bank numbers.
package al_accel_ibuf_ctrl_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DIM_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_SHIFT      = 3'd2,
    ST_DOWN_FETCH = 3'd3,
    ST_DOWN_LOAD  = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  localparam logic DIR_L2R = 1'b0;
  localparam logic DIR_R2L = 1'b1;

  localparam logic [2:0] WSTRB_FULL = 3'd0;
  localparam logic [2:0] WSTRB_OVLP = 3'd3;

  localparam logic [1:0] BANK_1 = 2'd1;
  localparam logic [1:0] BANK_2 = 2'd2;
  localparam logic [1:0] BANK_3 = 2'd3;

endpackage

// File: rtl/al_accel_ibuf_addr_gen.sv
// Strip-row / column counters for the serpentine scan and the
// base + row*W + col word-address multiply-add.
module al_accel_ibuf_addr_gen
  import al_accel_ibuf_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enb,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [DIM_W-1:0]  i_w,
  input  logic [DIM_W-1:0]  i_h,
  input  logic              i_dir,
  input  logic [1:0]        i_row_off,
  input  logic              i_col_step,
  input  logic              i_row_step,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_col,
  output logic              o_last_strip
);

  logic [ADDR_W-1:0] r_base;
  logic [DIM_W-1:0]  r_w;
  logic [DIM_W-1:0]  r_h;
  logic [DIM_W-1:0]  r_row;
  logic [DIM_W-1:0]  r_col;
  logic [ADDR_W-1:0] w_row_abs;
  logic [DIM_W:0]    w_row_p3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base <= '0;
      r_w    <= '0;
      r_h    <= '0;
      r_row  <= '0;
      r_col  <= '0;
    end else if (i_enb) begin
      if (i_start) begin
        r_base <= i_base;
        r_w    <= i_w;
        r_h    <= i_h;
        r_row  <= '0;
        r_col  <= '0;
      end else begin
        if (i_col_step) r_col <= (i_dir == DIR_R2L) ? r_col - DIM_W'(1) : r_col + DIM_W'(1);
        if (i_row_step) r_row <= r_row + DIM_W'(1);
      end
    end
  end

  // i_row_off selects which of the strip's rows (0..2, or 3 for the row below) is read.
  assign w_row_abs    = ADDR_W'(r_row) + ADDR_W'(i_row_off);
  assign o_addr       = r_base + w_row_abs * ADDR_W'(r_w) + ADDR_W'(r_col);
  assign o_last_col   = (i_dir == DIR_R2L) ? (r_col == '0) : (r_col == r_w - DIM_W'(1));
  assign w_row_p3     = {1'b0, r_row} + (DIM_W+1)'(3);
  assign o_last_strip = (w_row_p3 == {1'b0, r_h});

endmodule

// File: rtl/al_accel_ibuf_ctrl.sv
// Serpentine strip sequencer for al_accel_ibuf: fetches 3-row columns, shifts
// 4 windows per word, and steps down one row at the end of each strip.
module al_accel_ibuf_ctrl
  import al_accel_ibuf_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [DIM_W-1:0]  cfg_w_words,
  input  logic [DIM_W-1:0]  cfg_h,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ibuf_di,
  output logic              ibuf_ld_wrn,
  output logic [1:0]        ibuf_bank_sel,
  output logic              ibuf_di_revert,
  output logic [2:0]        ibuf_conv_wstrb,
  output logic              ibuf_conv_fi_load,
  output logic              ibuf_conv_se_load,
  output logic              ibuf_enb,
  output logic              win_valid,
  input  logic              win_stall,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  state_t            r_state;
  logic [1:0]        r_bank;
  logic [1:0]        r_shift;
  logic              r_dir;
  logic              r_ovlp;
  logic              w_fetch, w_shift, w_dfetch, w_dload;
  logic              w_start, w_shift_go, w_col_step;
  logic              w_last_col, w_last_strip;
  logic [1:0]        w_row_off;
  logic [ADDR_W-1:0] w_addr;

  assign w_fetch    = (r_state == ST_FETCH);
  assign w_shift    = (r_state == ST_SHIFT);
  assign w_dfetch   = (r_state == ST_DOWN_FETCH);
  assign w_dload    = (r_state == ST_DOWN_LOAD);
  assign w_start    = (r_state == ST_IDLE) && cfg_start;
  assign w_shift_go = w_shift && !win_stall;
  assign w_col_step = w_shift_go && (r_shift == 2'd3) && !w_last_col;
  assign w_row_off  = w_dfetch ? 2'd3 : r_bank;

  al_accel_ibuf_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .i_enb        (enb),
    .i_start      (w_start),
    .i_base       (cfg_base),
    .i_w          (cfg_w_words),
    .i_h          (cfg_h),
    .i_dir        (r_dir),
    .i_row_off    (w_row_off),
    .i_col_step   (w_col_step),
    .i_row_step   (w_dload),
    .o_addr       (w_addr),
    .o_last_col   (w_last_col),
    .o_last_strip (w_last_strip)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_bank  <= '0;
      r_shift <= '0;
      r_dir   <= DIR_L2R;
      r_ovlp  <= 1'b0;
    end else if (enb) begin
      case (r_state)
        ST_IDLE: if (cfg_start) begin
          r_bank  <= '0;
          r_shift <= '0;
          r_dir   <= DIR_L2R;
          r_ovlp  <= 1'b0;
          r_state <= (cfg_h >= DIM_W'(3)) ? ST_FETCH : ST_DONE;
        end
        ST_FETCH: if (mem_ready) begin
          if (r_bank == 2'd2) begin
            r_bank  <= '0;
            r_ovlp  <= 1'b0;
            r_state <= ST_SHIFT;
          end else begin
            r_bank <= r_bank + 2'd1;
          end
        end
        ST_SHIFT: if (!win_stall) begin
          r_shift <= r_shift + 2'd1;
          if (r_shift == 2'd3) begin
            if (!w_last_col)       r_state <= ST_FETCH;
            else if (w_last_strip) r_state <= ST_DONE;
            else                   r_state <= ST_DOWN_FETCH;
          end
        end
        ST_DOWN_FETCH: if (mem_ready) r_state <= ST_DOWN_LOAD;
        // The column under the turn is already in the ibuf; only the new row was read.
        ST_DOWN_LOAD: begin
          r_dir   <= ~r_dir;
          r_ovlp  <= 1'b1;
          r_state <= ST_SHIFT;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port: mem_valid/mem_addr hold until mem_ready; a transfer happens
  // only in a cycle with mem_valid && mem_ready (&& enb); mem_ready alone is ignored.
  assign mem_valid         = w_fetch || w_dfetch;
  assign mem_addr          = mem_valid ? w_addr : '0;
  assign ibuf_di           = mem_rdata;
  assign ibuf_ld_wrn       = mem_valid;
  assign ibuf_bank_sel     = w_fetch ? (r_bank + BANK_1) : (w_dfetch ? BANK_3 : 2'd0);
  assign ibuf_di_revert    = (w_dfetch || w_dload) ? ~r_dir : ((w_fetch || w_shift) ? r_dir : 1'b0);
  assign ibuf_conv_wstrb   = (w_fetch && r_ovlp) ? WSTRB_OVLP : WSTRB_FULL;
  assign ibuf_conv_fi_load = w_dload;
  assign ibuf_conv_se_load = w_dload;
  assign ibuf_enb          = enb && (mem_valid ? mem_ready : (w_shift ? !win_stall : w_dload));
  assign win_valid         = enb && w_shift_go;
  assign busy              = w_fetch || w_shift || w_dfetch || w_dload;
  assign done              = (r_state == ST_DONE);
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_al_accel_ibuf_ctrl.sv
// Directed bench for al_accel_ibuf_ctrl: a snake-scan model fills a queue of
// expected reads, a memory responder pops and compares them as they happen.
module tb_al_accel_ibuf_ctrl;

  localparam int RW = 22;

  logic        clk;
  logic        reset, enb, cfg_start;
  logic [15:0] cfg_base;
  logic [7:0]  cfg_w_words, cfg_h;
  logic        mem_valid, mem_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata, ibuf_di;
  logic        ibuf_ld_wrn, ibuf_di_revert, fi_load, se_load, ibuf_enb;
  logic [1:0]  ibuf_bank_sel;
  logic [2:0]  ibuf_conv_wstrb, dbg_state;
  logic        win_valid, win_stall, busy, done;

  logic [RW-1:0] exp_q[$];
  int n_cmp = 0, n_fail = 0;
  int lat = 0, wait_cnt = 0;
  int win_cnt = 0, exp_win = 0, load_cnt = 0, exp_loads = 0, done_cnt = 0;
  logic any_valid = 1'b0;
  logic prev_wait = 1'b0;
  logic [15:0] prev_addr = '0;

  al_accel_ibuf_ctrl dut (
    .clk(clk), .reset(reset), .enb(enb), .cfg_start(cfg_start),
    .cfg_base(cfg_base), .cfg_w_words(cfg_w_words), .cfg_h(cfg_h),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ibuf_di(ibuf_di), .ibuf_ld_wrn(ibuf_ld_wrn), .ibuf_bank_sel(ibuf_bank_sel),
    .ibuf_di_revert(ibuf_di_revert), .ibuf_conv_wstrb(ibuf_conv_wstrb),
    .ibuf_conv_fi_load(fi_load), .ibuf_conv_se_load(se_load), .ibuf_enb(ibuf_enb),
    .win_valid(win_valid), .win_stall(win_stall), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rec(input int a, input int b, input int s, input logic r);
    return {16'(a), 2'(b), 3'(s), r};
  endfunction

  // Reference snake scan: strip 0 reads every column; each later strip first reads
  // the row below at the turn column, then the remaining columns in its direction.
  task automatic push_frame(input int base, input int w, input int h);
    for (int r = 0; r <= h - 3; r++) begin
      logic rv;
      rv = ((r % 2) == 1);
      if (r == 0) begin
        for (int c = 0; c < w; c++)
          for (int k = 0; k < 3; k++) exp_q.push_back(rec(base + k*w + c, k + 1, 0, 1'b0));
      end else begin
        int c0;
        c0 = rv ? w - 1 : 0;
        exp_q.push_back(rec(base + (r+2)*w + c0, 3, 0, rv));
        for (int j = 1; j < w; j++) begin
          int c;
          c = rv ? w - 1 - j : j;
          for (int k = 0; k < 3; k++)
            exp_q.push_back(rec(base + (r+k)*w + c, k + 1, (j == 1) ? 3 : 0, rv));
        end
      end
    end
  endtask

  // driver tasks
  task automatic start_frame(input int base, input int w, input int h);
    push_frame(base, w, h);
    exp_win   = (h >= 3) ? 4*w*(h-2) : 0;
    exp_loads = (h >= 3) ? h - 3 : 0;
    win_cnt   = 0;
    load_cnt  = 0;
    @(negedge clk);
    cfg_base = 16'(base); cfg_w_words = 8'(w); cfg_h = 8'(h);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int dc;
    dc = done_cnt;
    for (int k = 0; k < budget && done_cnt == dc; k++) @(negedge clk);
    #2;
    chk("done_seen", done_cnt, dc + 1);
  endtask

  // memory responder + scoreboard
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rdata = $urandom;
      if (mem_valid) mem_ready = (wait_cnt >= lat);
      else           mem_ready = (lat == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (reset) begin
        prev_wait = 1'b0;
        wait_cnt  = 0;
      end else begin
        if (mem_valid && mem_ready && enb) begin
          if (exp_q.size() == 0) chk("extra_read", exp_q.size(), 1);
          else begin
            logic [RW-1:0] e;
            e = exp_q.pop_front();
            chk("read", {mem_addr, ibuf_bank_sel, ibuf_conv_wstrb, ibuf_di_revert}, e);
            chk("ld_enb", {ibuf_ld_wrn, ibuf_enb}, 2'b11);
            chk("di", ibuf_di, mem_rdata);
          end
          wait_cnt = 0;
        end else if (mem_valid && enb) begin
          chk("wait_enb", ibuf_enb, 0);
          wait_cnt++;
        end
        if (prev_wait && mem_valid) chk("addr_stable", mem_addr, prev_addr);
        prev_wait = mem_valid && !(mem_ready && enb);
        prev_addr = mem_addr;
        if (mem_valid) any_valid = 1'b1;
        if (win_valid) win_cnt++;
        if (fi_load) begin
          load_cnt++;
          chk("se_load", se_load, 1);
        end
        if (done) begin
          done_cnt++;
          chk("busy_at_done", busy, 0);
          chk("windows", win_cnt, exp_win);
          chk("reads_left", exp_q.size(), 0);
          chk("loads", load_cnt, exp_loads);
        end
      end
    end
  end

  // directed sequence
  initial begin
    int dc;
    logic [15:0] hold_addr;
    logic [2:0]  hold_state;
    logic        seen;
    reset = 1'b1; enb = 1'b1; cfg_start = 1'b0; win_stall = 1'b0;
    cfg_base = '0; cfg_w_words = '0; cfg_h = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_outputs", {mem_valid, busy, done, ibuf_enb, win_valid, ibuf_ld_wrn}, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b0;

    // reset mid-frame aborts without done
    start_frame(16'h100, 2, 4);
    repeat (8) @(negedge clk);
    dc = done_cnt;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("midrst_ctl", {mem_valid, busy, done, ibuf_enb, win_valid, ibuf_ld_wrn, fi_load, se_load, ibuf_di_revert}, 0);
    chk("midrst_mem", {mem_addr, ibuf_bank_sel, ibuf_conv_wstrb}, 0);
    chk("midrst_state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    chk("midrst_no_done", done_cnt, dc);

    // addresses and windows, ready always high
    start_frame(16'h100, 2, 4);
    wait_done(200);

    // two wait cycles per read
    lat = 2;
    start_frame(16'h100, 2, 4);
    wait_done(400);
    lat = 0;

    // PE back-pressure inside a SHIFT
    start_frame(16'h100, 2, 4);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      #2;
      seen = win_valid;
    end
    chk("stall_found_window", seen, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      win_stall = 1'b1;
      #2;
      chk("stall_outputs", {ibuf_enb, win_valid}, 0);
    end
    @(negedge clk);
    win_stall = 1'b0;
    wait_done(200);

    // short image: straight to DONE
    dc = done_cnt;
    any_valid = 1'b0;
    start_frame(16'h100, 2, 2);
    #2;
    chk("h2_done_latency", done_cnt, dc + 1);
    repeat (3) @(negedge clk);
    chk("h2_no_mem", any_valid, 0);

    // single-word rows
    lat = 1;
    start_frame(16'h200, 1, 5);
    wait_done(200);
    lat = 0;

    // freeze mid-FETCH, then a start while busy
    start_frame(16'h300, 3, 5);
    enb = 1'b0;
    #2;
    hold_addr  = mem_addr;
    hold_state = dbg_state;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #2;
      chk("frz_addr", mem_addr, hold_addr);
      chk("frz_state", dbg_state, hold_state);
      chk("frz_enb", {ibuf_enb, win_valid}, 0);
    end
    @(negedge clk);
    enb = 1'b1;
    repeat (3) @(negedge clk);
    cfg_base = 16'h0; cfg_w_words = 8'd1; cfg_h = 8'd3;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_done(400);
    repeat (3) @(negedge clk);
    #2;
    chk("no_restart", {busy, dbg_state}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
